// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the I/O port responder slice.
//   DATA_W_DEFAULT - default word width on both the CPU and host sides.
//   STAT_CNT_W     - count field width of the generic FIFO status record.
//   fifo_status_t  - {count, full, empty} snapshot of one FIFO.
//   ptr_width()    - read/write pointer width for a FIFO of a given depth.
package io_pkg;

  localparam int unsigned DATA_W_DEFAULT = 64;
  localparam int unsigned STAT_CNT_W     = 16;

  typedef struct packed {
    logic [STAT_CNT_W-1:0] count;
    logic                  full;
    logic                  empty;
  } fifo_status_t;

  // A depth-1 FIFO would give a zero-width pointer, so one bit is the minimum.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/io_port_responder_if.sv
// io_port_if: CPU strobe/data pins plus the host producer/consumer handshakes.
//   master - the CPU and host side (drives strobes, producer data, consumer ready).
//   slave  - the responder (drives cpu_in_data, host_in_ready, host_out_*).
interface io_port_if
  import io_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic              cpu_in_signal;
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_out_signal;
  logic [DATA_W-1:0] cpu_out_data;
  logic              host_in_valid;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_ready;
  logic              host_out_valid;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_ready;

  modport master (
    output cpu_in_signal, cpu_out_signal, cpu_out_data,
    output host_in_valid, host_in_data, host_out_ready,
    input  cpu_in_data, host_in_ready, host_out_valid, host_out_data
  );

  modport slave (
    input  cpu_in_signal, cpu_out_signal, cpu_out_data,
    input  host_in_valid, host_in_data, host_out_ready,
    output cpu_in_data, host_in_ready, host_out_valid, host_out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, full/empty decided from the occupancy count.
//   push/push_data - write request, ignored while full.
//   pop            - read request, ignored while empty (no fall-through).
//   head           - word at the read pointer (meaningful only when !empty).
//   count/full/empty - occupancy status.
module sync_fifo
  import io_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never read while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: I/O-port peripheral answering CPU reads and capturing CPU writes.
//   clk, reset      - clock, synchronous active-high reset.
//   bus (slave)     - CPU in/out strobes and data, host producer and consumer handshakes.
//   clear_flags     - clears both sticky error flags (a new error in the same cycle wins).
//   in_count/out_count       - input/output FIFO occupancy.
//   in_underflow/out_overflow - sticky CPU read-while-empty / write-while-full flags.
module io_port_responder
  import io_pkg::*;
#(
  parameter  int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter  int unsigned IN_DEPTH  = 16,
  parameter  int unsigned OUT_DEPTH = 16,
  localparam int unsigned IN_CNT_W  = $clog2(IN_DEPTH) + 1,
  localparam int unsigned OUT_CNT_W = $clog2(OUT_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  io_port_if.slave             bus,
  input  logic                 clear_flags,
  output logic [IN_CNT_W-1:0]  in_count,
  output logic [OUT_CNT_W-1:0] out_count,
  output logic                 in_underflow,
  output logic                 out_overflow
);

  logic              in_q, in_d;
  logic              out_q, out_d;
  logic              out_pend_q, out_pend_d;
  logic [DATA_W-1:0] out_word_q, out_word_d;
  logic              in_underflow_q, in_underflow_d;
  logic              out_overflow_q, out_overflow_d;

  logic              in_evt_s, out_evt_s;
  logic [DATA_W-1:0] in_head_s;
  logic              in_full_s, in_empty_s;
  logic              out_full_s, out_empty_s;

  assign in_evt_s  = bus.cpu_in_signal & ~in_q;
  assign out_evt_s = bus.cpu_out_signal & ~out_q;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.host_in_valid & ~in_full_s),
    .push_data (bus.host_in_data),
    .pop       (in_evt_s),
    .head      (in_head_s),
    .count     (in_count),
    .full      (in_full_s),
    .empty     (in_empty_s)
  );

  // The write is staged one cycle: the word is sampled on the event and pushed
  // on the following edge, so full/overflow are judged at the push itself.
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_pend_q),
    .push_data (out_word_q),
    .pop       (bus.host_out_ready & ~out_empty_s),
    .head      (bus.host_out_data),
    .count     (out_count),
    .full      (out_full_s),
    .empty     (out_empty_s)
  );

  // The CPU samples in_data in the same cycle it raises in_signal, so this stays combinational.
  assign bus.cpu_in_data    = in_empty_s ? {DATA_W{1'b0}} : in_head_s;
  assign bus.host_in_ready  = ~in_full_s;
  assign bus.host_out_valid = ~out_empty_s;
  assign in_underflow       = in_underflow_q;
  assign out_overflow       = out_overflow_q;

  // Edge-detect history, staged CPU write and sticky flags (set beats clear).
  always_comb begin
    in_d       = bus.cpu_in_signal;
    out_d      = bus.cpu_out_signal;
    out_pend_d = out_evt_s;
    out_word_d = out_word_q;
    if (out_evt_s) begin
      out_word_d = bus.cpu_out_data;
    end else begin
      out_word_d = out_word_q;
    end
    if (in_evt_s & in_empty_s) begin
      in_underflow_d = 1'b1;
    end else if (clear_flags) begin
      in_underflow_d = 1'b0;
    end else begin
      in_underflow_d = in_underflow_q;
    end
    if (out_pend_q & out_full_s) begin
      out_overflow_d = 1'b1;
    end else if (clear_flags) begin
      out_overflow_d = 1'b0;
    end else begin
      out_overflow_d = out_overflow_q;
    end
  end

  // Control registers; reset discards any staged write and clears the flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q           <= 1'b0;
      out_q          <= 1'b0;
      out_pend_q     <= 1'b0;
      out_word_q     <= {DATA_W{1'b0}};
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      in_q           <= in_d;
      out_q          <= out_d;
      out_pend_q     <= out_pend_d;
      out_word_q     <= out_word_d;
      in_underflow_q <= in_underflow_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed self-checking bench for io_port_responder.
// Inputs change and outputs are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_io_port_responder;
  import io_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_flags;
  logic [4:0] in_count;
  logic [4:0] out_count;
  logic       in_underflow;
  logic       out_overflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  io_port_if #(.DATA_W(64)) bus ();

  io_port_responder #(.DATA_W(64), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_flags  (clear_flags),
    .in_count     (in_count),
    .out_count    (out_count),
    .in_underflow (in_underflow),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // One-cycle in_signal pulse followed by three idle cycles.
  task automatic cpu_read_pulse();
    bus.cpu_in_signal = 1'b1;
    step(1);
    bus.cpu_in_signal = 1'b0;
    step(3);
  endtask

  task automatic cpu_write(input logic [63:0] w);
    bus.cpu_out_data   = w;
    bus.cpu_out_signal = 1'b1;
    step(1);
    bus.cpu_out_signal = 1'b0;
    step(3);
  endtask

  task automatic host_push(input logic [63:0] w);
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = w;
    step(1);
    bus.host_in_valid = 1'b0;
  endtask

  logic [63:0] exp_rd [3];

  initial begin
    exp_rd[0] = 64'h11; exp_rd[1] = 64'h22; exp_rd[2] = 64'h33;
    reset = 1'b1;
    clear_flags = 1'b0;
    bus.cpu_in_signal = 1'b0;
    bus.cpu_out_signal = 1'b0;
    bus.cpu_out_data = 64'h0;
    bus.host_in_valid = 1'b0;
    bus.host_in_data = 64'h0;
    bus.host_out_ready = 1'b0;
    step(2);

    // Reset state.
    check_eq("rst_in_ready", 64'(bus.host_in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.host_out_valid), 64'd0);
    check_eq("rst_cpu_in_data", bus.cpu_in_data, 64'd0);
    check_eq("rst_in_count", 64'(in_count), 64'd0);
    check_eq("rst_out_count", 64'(out_count), 64'd0);
    check_eq("rst_flags", 64'({in_underflow, out_overflow}), 64'd0);
    reset = 1'b0;
    step(1);

    // Three host words, read back by three CPU pulses.
    host_push(64'h11);
    host_push(64'h22);
    host_push(64'h33);
    check_eq("rd_count3", 64'(in_count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      bus.cpu_in_signal = 1'b1;
      #1;
      check_eq("rd_data", bus.cpu_in_data, exp_rd[i]);
      step(1);
      bus.cpu_in_signal = 1'b0;
      check_eq("rd_count", 64'(in_count), 64'(2 - i));
      step(3);
    end
    check_eq("rd_data_empty", bus.cpu_in_data, 64'd0);
    check_eq("rd_no_underflow", 64'(in_underflow), 64'd0);

    // Read on empty FIFO: underflow, then clear, then set-beats-clear.
    bus.cpu_in_signal = 1'b1;
    #1;
    check_eq("uf_data", bus.cpu_in_data, 64'd0);
    step(1);
    bus.cpu_in_signal = 1'b0;
    check_eq("uf_flag", 64'(in_underflow), 64'd1);
    check_eq("uf_count", 64'(in_count), 64'd0);
    step(3);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    check_eq("uf_cleared", 64'(in_underflow), 64'd0);
    step(2);
    bus.cpu_in_signal = 1'b1;
    clear_flags = 1'b1;
    step(1);
    bus.cpu_in_signal = 1'b0;
    clear_flags = 1'b0;
    check_eq("uf_set_wins", 64'(in_underflow), 64'd1);
    step(3);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;

    // 17 CPU writes into a 16-deep FIFO with the consumer stalled.
    bus.cpu_out_data = 64'd0;
    bus.cpu_out_signal = 1'b1;
    step(1);
    bus.cpu_out_signal = 1'b0;
    check_eq("wr_lat1_valid", 64'(bus.host_out_valid), 64'd0);
    step(1);
    check_eq("wr_lat2_valid", 64'(bus.host_out_valid), 64'd1);
    step(2);
    for (int w = 1; w < 16; w++) cpu_write(64'(w));
    check_eq("wr_no_ovf_at16", 64'(out_overflow), 64'd0);
    cpu_write(64'd16);
    check_eq("wr_count_full", 64'(out_count), 64'd16);
    check_eq("wr_overflow", 64'(out_overflow), 64'd1);
    check_eq("wr_in_ready", 64'(bus.host_in_ready), 64'd1);
    step(1);
    check_eq("wr_hold_data", bus.host_out_data, 64'd0);
    bus.host_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 64'(bus.host_out_valid), 64'd1);
      check_eq("drain_data", bus.host_out_data, 64'(i));
      step(1);
    end
    bus.host_out_ready = 1'b0;
    check_eq("drain_empty", 64'(bus.host_out_valid), 64'd0);
    check_eq("drain_count", 64'(out_count), 64'd0);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    check_eq("ovf_cleared", 64'(out_overflow), 64'd0);

    // in_signal held high five cycles pops once.
    host_push(64'hA1);
    host_push(64'hA2);
    check_eq("hold_count2", 64'(in_count), 64'd2);
    bus.cpu_in_signal = 1'b1;
    step(5);
    bus.cpu_in_signal = 1'b0;
    check_eq("hold_count1", 64'(in_count), 64'd1);
    check_eq("hold_head", bus.cpu_in_data, 64'hA2);
    step(3);
    cpu_read_pulse();
    check_eq("hold_drained", 64'(in_count), 64'd0);

    // Output FIFO at one entry: staged CPU write lands in the same cycle as a host pop.
    cpu_write(64'h55);
    check_eq("sim_count1", 64'(out_count), 64'd1);
    bus.cpu_out_data = 64'h66;
    bus.cpu_out_signal = 1'b1;
    step(1);
    bus.cpu_out_signal = 1'b0;
    bus.host_out_ready = 1'b1;
    check_eq("sim_head_old", bus.host_out_data, 64'h55);
    check_eq("sim_count_pre", 64'(out_count), 64'd1);
    step(1);
    bus.host_out_ready = 1'b0;
    check_eq("sim_count_post", 64'(out_count), 64'd1);
    check_eq("sim_head_new", bus.host_out_data, 64'h66);
    bus.host_out_ready = 1'b1;
    step(1);
    bus.host_out_ready = 1'b0;
    check_eq("sim_drained", 64'(out_count), 64'd0);

    // Reset with both FIFOs half full, a flag set and a host push in flight.
    cpu_read_pulse();
    for (int i = 0; i < 8; i++) host_push(64'(32'hB0 + i));
    for (int i = 0; i < 8; i++) cpu_write(64'(32'hC0 + i));
    check_eq("pre_rst_in", 64'(in_count), 64'd8);
    check_eq("pre_rst_out", 64'(out_count), 64'd8);
    check_eq("pre_rst_uf", 64'(in_underflow), 64'd1);
    reset = 1'b1;
    bus.host_in_valid = 1'b1;
    bus.host_in_data = 64'hDEAD;
    step(1);
    reset = 1'b0;
    bus.host_in_valid = 1'b0;
    check_eq("rst2_in_count", 64'(in_count), 64'd0);
    check_eq("rst2_out_count", 64'(out_count), 64'd0);
    check_eq("rst2_out_valid", 64'(bus.host_out_valid), 64'd0);
    check_eq("rst2_flags", 64'({in_underflow, out_overflow}), 64'd0);
    check_eq("rst2_cpu_in_data", bus.cpu_in_data, 64'd0);
    check_eq("rst2_in_ready", 64'(bus.host_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
